// File: rtl/load_store_unit.sv
// Load/store unit: formats RISC-V byte/half/word accesses onto a word-wide req/gnt/rvalid data port.
// Latency: store 2 cycles (accept, grant); load 3 cycles to rvalid, registered writeback one cycle later.
// Backpressure: stall_o holds execute until the grant (store) or rvalid (load); request held until granted.
module load_store_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lsu_valid_i,
  input  logic          lsu_we_i,
  input  logic [2:0]    func3_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [4:0]    rd_i,
  input  logic          flush_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_wstrb_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          stall_o,
  output logic          wb_valid_o,
  output logic [4:0]    wb_rd_o,
  output logic [DW-1:0] wb_data_o,
  output logic          err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q;
  logic          we_q;
  logic [2:0]    func3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wstrb_q;

  logic          legal;
  logic          aligned;
  logic          accept;
  logic          bad_access;
  logic [DW-1:0] st_wdata;
  logic [3:0]    st_wstrb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;

  // Decode legality/alignment of the execute-stage access and lane-align store data
  always_comb begin
    legal    = 1'b0;
    aligned  = 1'b1;
    st_wdata = wdata_i;
    st_wstrb = 4'b1111;
    case (func3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !lsu_we_i;  // unsigned variants exist only for loads
      default:                legal = 1'b0;
    endcase
    case (func3_i)
      3'b001, 3'b101: aligned = !addr_i[0];
      3'b010:         aligned = (addr_i[1:0] == 2'b00);
      default:        aligned = 1'b1;
    endcase
    case (func3_i[1:0])
      2'b00: begin
        st_wdata = {4{wdata_i[7:0]}};
        st_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_i[15:0]}};
        st_wstrb = 4'b0011 << addr_i[1:0];
      end
      default: begin
        st_wdata = wdata_i;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign accept     = (state_q == S_IDLE) && lsu_valid_i && !flush_i && legal && aligned;
  assign bad_access = (state_q == S_IDLE) && lsu_valid_i && !flush_i && !(legal && aligned);

  // Extract and extend the addressed byte/halfword from the returned word
  always_comb begin
    ld_byte = mem_rdata_i[7:0];
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (func3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Access FSM: latch the accepted access, hold the request until granted, wait for load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_REQ;
            we_q    <= lsu_we_i;
            func3_q <= func3_i;
            off_q   <= addr_i[1:0];
            rd_q    <= rd_i;
            addr_q  <= {addr_i[DW-1:2], 2'b00};
            wdata_q <= st_wdata;
            wstrb_q <= st_wstrb;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) state_q <= we_q ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register load writeback one cycle after read data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= 5'd0;
      wb_data_o  <= '0;
    end else begin
      wb_valid_o <= (state_q == S_WAIT) && mem_rvalid_i;
      if ((state_q == S_WAIT) && mem_rvalid_i) begin
        wb_rd_o   <= rd_q;
        wb_data_o <= ld_data;
      end
    end
  end

  // Memory port and pipeline control; combinational outputs are forced low while in reset
  always_comb begin
    mem_req_o   = (state_q == S_REQ);
    mem_we_o    = (state_q == S_REQ) && we_q;
    mem_wstrb_o = (state_q == S_REQ) ? wstrb_q : 4'd0;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    stall_o     = rst_n && (accept ||
                            ((state_q == S_REQ) && !(we_q && mem_gnt_i)) ||
                            ((state_q == S_WAIT) && !mem_rvalid_i));
    err_o       = rst_n && bad_access;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a writeback scoreboard.
// Inputs change on the falling edge; outputs are sampled 1ns later or on the falling edge.
// Expected loads are queued when issued and popped when wb_valid_o appears.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];

  load_store_unit #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid), .lsu_we_i(lsu_we), .func3_i(func3),
    .addr_i(addr), .wdata_i(wdata), .rd_i(rd), .flush_i(flush),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Scoreboard: every writeback must match the oldest queued load
  always @(negedge clk) begin
    if (rst_n && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'd1, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_rd_data", {27'd0, wb_rd, wb_data}, {27'd0, e});
      end
    end
  end

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input logic [31:0] ea, input logic [31:0] ew,
                          input logic [3:0] es);
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; func3 = f3; addr = a; wdata = wd; flush = 1'b0;
    #1;
    check("st_accept_stall", stall, 1);
    check("st_accept_noreq", mem_req, 0);
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    for (int i = 0; i < gd; i++) begin
      mem_gnt = 1'b0;
      #1;
      check("st_req_held", mem_req, 1);
      check("st_held_addr", mem_addr, ea);
      check("st_stall_nogrant", stall, 1);
      @(posedge clk);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    #1;
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, ea);
    check("st_wdata", mem_wdata, ew);
    check("st_wstrb", mem_wstrb, es);
    check("st_stall_grant", stall, 0);
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("st_req_done", mem_req, 0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                         input logic [31:0] rdat, input int gd, input logic fl_req,
                         input logic [31:0] ea, input logic [31:0] exp_data);
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; func3 = f3; addr = a; rd = r; flush = 1'b0;
    exp_q.push_back({r, exp_data});
    #1;
    check("ld_accept_stall", stall, 1);
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0; flush = fl_req;
    for (int i = 0; i < gd; i++) begin
      mem_gnt = 1'b0;
      #1;
      check("ld_req_held", mem_req, 1);
      @(posedge clk);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    #1;
    check("ld_req", mem_req, 1);
    check("ld_we", mem_we, 0);
    check("ld_addr", mem_addr, ea);
    check("ld_stall_grant", stall, 1);
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdat;
    #1;
    check("ld_wait_noreq", mem_req, 0);
    check("ld_stall_rvalid", stall, 0);
    check("ld_wb_early", wb_valid, 0);
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("ld_wb_valid", wb_valid, 1);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_valid = 1'b1; lsu_we = 1'b0; func3 = 3'b010; addr = 32'h0; wdata = 32'h0;
    rd = 5'd1; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #2;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_err", err, 0);
    check("rst_wb", wb_valid, 0);
    check("rst_strb", mem_wstrb, 0);
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // SW with one-cycle late grant, then SB/SH lane formatting
    do_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    do_store(3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000);
    do_store(3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 32'h0000_0100, 32'hBEEF_BEEF, 4'b1100);

    // Loads with sign/zero extension
    do_load(3'b000, 32'h0000_0201, 5'd3,  32'h0000_8000, 0, 1'b0, 32'h0000_0200, 32'hFFFF_FF80);
    do_load(3'b100, 32'h0000_0201, 5'd4,  32'h0000_8000, 1, 1'b0, 32'h0000_0200, 32'h0000_0080);
    do_load(3'b001, 32'h0000_0202, 5'd5,  32'h8001_1234, 0, 1'b0, 32'h0000_0200, 32'hFFFF_8001);
    do_load(3'b101, 32'h0000_0202, 5'd6,  32'h8001_1234, 0, 1'b0, 32'h0000_0200, 32'h0000_8001);
    // Flush while in REQ must not cancel the access
    do_load(3'b010, 32'h0000_0204, 5'd31, 32'h1234_5678, 1, 1'b1, 32'h0000_0204, 32'h1234_5678);

    // Misaligned LW: error pulse, no request, no stall
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0206;
    #1;
    check("mis_err", err, 1);
    check("mis_stall", stall, 0);
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    #1;
    check("mis_noreq", mem_req, 0);
    check("mis_err_clear", err, 0);

    // Illegal: LBU encoding used as a store
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; func3 = 3'b100; addr = 32'h0000_0300;
    #1;
    check("ill_err", err, 1);
    check("ill_stall", stall, 0);
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    #1;
    check("ill_noreq", mem_req, 0);

    // Flush in IDLE blocks acceptance; stray grant in IDLE is ignored
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0400; flush = 1'b1;
    mem_gnt = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    check("flush_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0; flush = 1'b0; mem_gnt = 1'b0;
    #1;
    check("flush_noreq", mem_req, 0);

    // Reset while in WAIT drops the load; later rvalid is ignored
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0500; rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("wait_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("rstw_req", mem_req, 0);
    check("rstw_stall", stall, 0);
    check("rstw_addr", mem_addr, 0);
    check("rstw_wb", wb_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("rstw_idle_stall", stall, 0);
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rstw_no_wb", wb_valid, 0);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
